// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: instruction/memory handshake inputs and the datapath strobes.
// slave is the control unit's view, master is the driver/observer's view.
interface multicycle_control_unit_if #(
    parameter int OPCODE_W = 4,
    parameter int ALUOP_W  = 2,
    parameter int CNT_W    = 16
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                stall;
    logic                PCWrite;
    logic                IRWrite;
    logic                MemRead;
    logic                MemWrite;
    logic                RegWrite;
    logic                RegDst;
    logic                MemToReg;
    logic                AluSrc;
    logic                Branch;
    logic [ALUOP_W-1:0]  ALUOp;
    logic                illegal_op;
    logic                mem_fault;
    logic                instr_done;
    logic [CNT_W-1:0]    instr_count;

    modport slave (
        input  opcode, mem_ready, stall,
        output PCWrite, IRWrite, MemRead, MemWrite, RegWrite, RegDst, MemToReg,
               AluSrc, Branch, ALUOp, illegal_op, mem_fault, instr_done, instr_count
    );

    modport master (
        output opcode, mem_ready, stall,
        input  PCWrite, IRWrite, MemRead, MemWrite, RegWrite, RegDst, MemToReg,
               AluSrc, Branch, ALUOp, illegal_op, mem_fault, instr_done, instr_count
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencing with a
// memory-ready timeout, decode stall, illegal-opcode pulse and retired-instruction counter.
module multicycle_control_unit #(
    parameter int OPCODE_W    = 4,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    multicycle_control_unit_if.slave  bus
);

    localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
    localparam bit TO_EN = (MEM_TIMEOUT != 0);

    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1111;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_op;
    logic [TO_W-1:0]     r_to_cnt;
    logic                r_illegal_op;
    logic [CNT_W-1:0]    r_instr_count;

    logic                w_mem_wait;
    logic                w_to_expire;
    logic                w_pc_write;
    logic                w_ir_write;
    logic                w_mem_read;
    logic                w_mem_write;
    logic                w_reg_write;
    logic                w_reg_dst;
    logic                w_mem_to_reg;
    logic                w_alu_src;
    logic                w_branch;
    logic [1:0]          w_alu_op;
    logic                w_instr_done;

    // Upper opcode bits must be zero; 1010/1011/1110 are unassigned codes.
    function automatic logic f_is_illegal(input logic [OPCODE_W-1:0] op);
        logic l_hi;
        logic l_lo;
        l_hi = |(op >> 4);
        case (op[3:0])
            4'b1010, 4'b1011, 4'b1110: l_lo = 1'b1;
            default:                   l_lo = 1'b0;
        endcase
        return l_hi | l_lo;
    endfunction

    function automatic logic f_is_rtype(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0010, 4'b0011, 4'b0100,
            4'b0110, 4'b0111, 4'b1100:          return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic f_is_imm(input logic [3:0] op);
        case (op)
            4'b0001, 4'b0101, 4'b1101: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    assign w_mem_wait  = ((r_state == S_FETCH) || (r_state == S_MEM)) && !bus.mem_ready;
    assign w_to_expire = TO_EN && w_mem_wait && (r_to_cnt == TO_LAST);

    // Next-state and strobe decode from the state register and latched opcode.
    always_comb begin
        w_next_state = r_state;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_src    = 1'b0;
        w_branch     = 1'b0;
        w_alu_op     = 2'b00;
        w_instr_done = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_next_state = S_DECODE;
                end else if (w_to_expire) begin
                    w_next_state = S_FAULT;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                if (bus.stall) begin
                    w_next_state = S_DECODE;
                end else if (f_is_illegal(bus.opcode)) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (f_is_rtype(r_op)) begin
                    w_reg_dst    = 1'b1;
                    w_alu_op     = 2'b10;
                    w_next_state = S_WRITEBACK;
                end else if (f_is_imm(r_op)) begin
                    w_alu_src    = 1'b1;
                    w_alu_op     = 2'b11;
                    w_next_state = S_WRITEBACK;
                end else if ((r_op == OP_LW) || (r_op == OP_SW)) begin
                    w_alu_src    = 1'b1;
                    w_alu_op     = 2'b00;
                    w_next_state = S_MEM;
                end else if (r_op == OP_BEQ) begin
                    w_branch     = 1'b1;
                    w_alu_op     = 2'b01;
                    w_instr_done = 1'b1;
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_MEM: begin
                w_alu_src = 1'b1;
                w_alu_op  = 2'b00;
                if (r_op == OP_LW) begin
                    w_mem_read = 1'b1;
                end else begin
                    w_mem_write = 1'b1;
                end
                if (bus.mem_ready) begin
                    if (r_op == OP_LW) begin
                        w_next_state = S_WRITEBACK;
                    end else begin
                        w_instr_done = 1'b1;
                        w_next_state = S_FETCH;
                    end
                end else if (w_to_expire) begin
                    w_next_state = S_FAULT;
                end else begin
                    w_next_state = S_MEM;
                end
            end
            S_WRITEBACK: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_reg_dst    = f_is_rtype(r_op);
                w_mem_to_reg = (r_op == OP_LW);
                w_next_state = S_FETCH;
            end
            S_FAULT: begin
                w_next_state = S_FAULT;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Opcode latch: captured on the DECODE edge only, so later input changes are ignored.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_op <= 4'd0;
        end else if ((r_state == S_DECODE) && !bus.stall) begin
            r_op <= bus.opcode[3:0];
        end else begin
            r_op <= r_op;
        end
    end

    // Wait counter: runs while FETCH/MEM waits, zero otherwise so every entry starts clean.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_to_cnt <= '0;
        end else if (TO_EN && w_mem_wait && !w_to_expire) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    // Illegal-opcode pulse, registered so it appears the cycle after the DECODE edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_illegal_op <= 1'b0;
        end else begin
            r_illegal_op <= (r_state == S_DECODE) && !bus.stall && f_is_illegal(bus.opcode);
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_instr_count <= '0;
        end else if (w_instr_done) begin
            r_instr_count <= r_instr_count + 1'b1;
        end else begin
            r_instr_count <= r_instr_count;
        end
    end

    assign bus.PCWrite     = w_pc_write;
    assign bus.IRWrite     = w_ir_write;
    assign bus.MemRead     = w_mem_read;
    assign bus.MemWrite    = w_mem_write;
    assign bus.RegWrite    = w_reg_write;
    assign bus.RegDst      = w_reg_dst;
    assign bus.MemToReg    = w_mem_to_reg;
    assign bus.AluSrc      = w_alu_src;
    assign bus.Branch      = w_branch;
    assign bus.ALUOp       = ALUOP_W'(w_alu_op);
    assign bus.illegal_op  = r_illegal_op;
    assign bus.mem_fault   = (r_state == S_FAULT);
    assign bus.instr_done  = w_instr_done;
    assign bus.instr_count = r_instr_count;

endmodule
